// File: rtl/team_06_voice_ctrl.sv
// Listen/talk arbitration FSM with debounced buttons, noise gate with hang time and N-way effect select.
// Optional talk timeout (LOCK state) is built when TEAM_06_TALK_TIMEOUT_EN is defined.
module team_06_voice_ctrl #(
    parameter int AUD_W       = 8,
    parameter int GATE_TH     = 64,
    parameter int SPK_TH      = 1,
    parameter int N_EFFECTS   = 5,
    parameter int DEB_CYC     = 4,
    parameter int HANG_CYC    = 8,
    parameter int TIMEOUT_CYC = 1024,
    localparam int EFF_W      = (N_EFFECTS > 2) ? $clog2(N_EFFECTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AUD_W-1:0] mic_aud,
    input  logic [AUD_W-1:0] spk_aud,
    input  logic             ptt_btn,
    input  logic             ng_btn,
    input  logic             mute_btn,
    input  logic             effect_btn,
    output logic [1:0]       state,
    output logic             vol_en,
    output logic             eff_en,
    output logic [EFF_W-1:0] current_effect,
    output logic             mute_tog,
    output logic             noise_gate_tog,
    output logic             timeout
);

    localparam int unsigned NBTN = 4;
    localparam int unsigned B_PTT  = 0;
    localparam int unsigned B_NG   = 1;
    localparam int unsigned B_MUTE = 2;
    localparam int unsigned B_EFF  = 3;

    localparam int DB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int HG_W = (HANG_CYC > 1) ? $clog2(HANG_CYC) : 1;

    localparam logic [AUD_W:0]    MID       = (AUD_W+1)'(2 ** (AUD_W - 1));
    localparam logic [AUD_W:0]    GATE_LIM  = (AUD_W+1)'(GATE_TH);
    localparam logic [AUD_W:0]    SPK_LIM   = (AUD_W+1)'(SPK_TH);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEB_CYC - 1);
    localparam logic [HG_W-1:0]   HANG_LOAD = HG_W'((HANG_CYC > 0) ? HANG_CYC - 1 : 0);
    localparam logic [EFF_W-1:0]  EFF_LAST  = EFF_W'(N_EFFECTS - 1);

    if (N_EFFECTS < 2) begin : g_chk_eff
        $error("N_EFFECTS must be at least 2");
    end
    if (DEB_CYC < 1) begin : g_chk_deb
        $error("DEB_CYC must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_to
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        LIST = 2'b00,
        TALK = 2'b01,
        HANG = 2'b10,
        LOCK = 2'b11
    } state_t;

    state_t cur, nxt;

    logic [NBTN-1:0] raw, sync1, sync2, db, pulse;
    logic [DB_W-1:0] cnt [NBTN];

    logic [AUD_W:0]  mic_ext, spk_ext, mic_dev, spk_dev;
    logic            loud, spk_active;
    logic            ptt_db;

    logic [HG_W-1:0] hang_cnt, hang_nxt;
    logic            talk_expired;

    assign raw    = {effect_btn, mute_btn, ng_btn, ptt_btn};
    assign ptt_db = db[B_PTT];

    // Two-flop synchroniser, then a level is accepted only after DEB_CYC stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            pulse <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NBTN; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]    <= sync2[i];
                    cnt[i]   <= '0;
                    pulse[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        mic_ext    = {1'b0, mic_aud};
        spk_ext    = {1'b0, spk_aud};
        mic_dev    = (mic_ext >= MID) ? (mic_ext - MID) : (MID - mic_ext);
        spk_dev    = (spk_ext >= MID) ? (spk_ext - MID) : (MID - spk_ext);
        loud       = (mic_dev >= GATE_LIM);
        spk_active = (spk_dev >= SPK_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mute_tog       <= 1'b0;
            noise_gate_tog <= 1'b0;
            current_effect <= '0;
        end else begin
            if (pulse[B_MUTE]) begin
                mute_tog <= ~mute_tog;
            end
            if (pulse[B_NG]) begin
                noise_gate_tog <= ~noise_gate_tog;
            end
            if (pulse[B_EFF]) begin
                current_effect <= (current_effect == EFF_LAST) ? '0 : current_effect + EFF_W'(1);
            end
        end
    end

`ifdef TEAM_06_TALK_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] talk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            talk_cnt <= '0;
        end else if (cur == TALK || cur == HANG) begin
            talk_cnt <= talk_cnt + TO_W'(1);
        end else begin
            talk_cnt <= '0;
        end
    end

    assign talk_expired = (cur == TALK || cur == HANG) && (talk_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign timeout      = (cur == LOCK);
`else
    assign talk_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= LIST;
            hang_cnt <= '0;
        end else begin
            cur      <= nxt;
            hang_cnt <= hang_nxt;
        end
    end

    always_comb begin
        nxt      = LIST;
        hang_nxt = hang_cnt;
        case (cur)
            LIST: begin
                if (spk_active)                   nxt = LIST;
                else if (ptt_db)                  nxt = TALK;
                else if (noise_gate_tog && loud)  nxt = TALK;
                else                              nxt = LIST;
            end
            TALK: begin
                if (spk_active)                   nxt = LIST;
                else if (ptt_db)                  nxt = TALK;
                else if (noise_gate_tog && loud)  nxt = TALK;
                else if (noise_gate_tog && HANG_CYC > 0) begin
                    nxt      = HANG;
                    hang_nxt = HANG_LOAD;
                end else                          nxt = LIST;
            end
            HANG: begin
                if (spk_active)                   nxt = LIST;
                else if (ptt_db || loud)          nxt = TALK;
                else if (!noise_gate_tog)         nxt = LIST;
                else if (hang_cnt == '0)          nxt = LIST;
                else begin
                    nxt      = HANG;
                    hang_nxt = hang_cnt - HG_W'(1);
                end
            end
            LOCK: begin
`ifdef TEAM_06_TALK_TIMEOUT_EN
                if (!ptt_db && !(noise_gate_tog && loud)) nxt = LIST;
                else                                      nxt = LOCK;
`else
                nxt = LIST;
`endif
            end
        endcase
        // Timeout outranks every other transition, including speaker activity.
        if (talk_expired) begin
            nxt = LOCK;
        end
    end

    assign state  = cur;
    assign vol_en = (cur == LIST || cur == LOCK) && !mute_tog && !rst;
    assign eff_en = (cur == TALK || cur == HANG) && (current_effect != '0) && !rst;

endmodule

// File: tb/tb_team_06_voice_ctrl.sv
// Directed, table-driven bench for team_06_voice_ctrl; hand sequences cover reset and talk timeout.
module tb_team_06_voice_ctrl;

    localparam logic [7:0] M = 8'h80;
    localparam logic [1:0] S_LIST = 2'b00;
    localparam logic [1:0] S_TALK = 2'b01;
    localparam logic [1:0] S_HANG = 2'b10;
    localparam logic [1:0] S_LOCK = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mic_aud, spk_aud;
    logic       ptt_btn, ng_btn, mute_btn, effect_btn;
    logic [1:0] state;
    logic       vol_en, eff_en;
    logic [2:0] current_effect;
    logic       mute_tog, noise_gate_tog, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    team_06_voice_ctrl #(
        .AUD_W      (8),
        .GATE_TH    (64),
        .SPK_TH     (1),
        .N_EFFECTS  (5),
        .DEB_CYC    (4),
        .HANG_CYC   (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mic_aud       (mic_aud),
        .spk_aud       (spk_aud),
        .ptt_btn       (ptt_btn),
        .ng_btn        (ng_btn),
        .mute_btn      (mute_btn),
        .effect_btn    (effect_btn),
        .state         (state),
        .vol_en        (vol_en),
        .eff_en        (eff_en),
        .current_effect(current_effect),
        .mute_tog      (mute_tog),
        .noise_gate_tog(noise_gate_tog),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mic;
        logic [7:0] spk;
        logic       ptt, ng, mute, eff;
        int         cyc;
        logic [1:0] st;
        logic       vol, effen;
        logic [2:0] effect;
        logic       mt, ngt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [7:0] mic, input logic [7:0] spk,
                                input logic ptt, input logic ng, input logic mute, input logic eff,
                                input int cyc, input logic [1:0] st, input logic vol, input logic effen,
                                input logic [2:0] effect, input logic mt, input logic ngt);
        vec_t v;
        v.mic = mic; v.spk = spk; v.ptt = ptt; v.ng = ng; v.mute = mute; v.eff = eff;
        v.cyc = cyc; v.st = st; v.vol = vol; v.effen = effen; v.effect = effect;
        v.mt = mt; v.ngt = ngt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [1:0] st, input logic vol, input logic effen,
                             input logic [2:0] effect, input logic mt, input logic ngt);
        chk("state",   idx, 8'(state),          8'(st));
        chk("vol_en",  idx, 8'(vol_en),         8'(vol));
        chk("eff_en",  idx, 8'(eff_en),         8'(effen));
        chk("effect",  idx, 8'(current_effect), 8'(effect));
        chk("mute",    idx, 8'(mute_tog),       8'(mt));
        chk("ng",      idx, 8'(noise_gate_tog), 8'(ngt));
        chk("timeout", idx, 8'(timeout),        8'(st == S_LOCK));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mic_aud = M; spk_aud = M;
        ptt_btn = 1'b0; ng_btn = 1'b0; mute_btn = 1'b0; effect_btn = 1'b0;
        step(2);
        check_all(900, S_LIST, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        add(M, M, 0, 0, 0, 0, 3, S_LIST, 1, 0, 3'd0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(M, M, 0, 0, 0, 1, 7, S_LIST, 1, 0, 3'(k % 5), 0, 0);
            add(M, M, 0, 0, 0, 0, 7, S_LIST, 1, 0, 3'(k % 5), 0, 0);
        end
        // ptt glitch rejected, then sustained press reaches TALK exactly at edge 7
        add(M, M, 1, 0, 0, 0, 2, S_LIST, 1, 0, 3'd0, 0, 0);
        add(M, M, 0, 0, 0, 0, 8, S_LIST, 1, 0, 3'd0, 0, 0);
        add(M, M, 1, 0, 0, 0, 6, S_LIST, 1, 0, 3'd0, 0, 0);
        add(M, M, 1, 0, 0, 0, 1, S_TALK, 0, 0, 3'd0, 0, 0);
        add(M, M, 0, 0, 0, 0, 6, S_TALK, 0, 0, 3'd0, 0, 0);
        add(M, M, 0, 0, 0, 0, 1, S_LIST, 1, 0, 3'd0, 0, 0);
        add(M, M, 0, 0, 0, 1, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        add(M, M, 0, 0, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        // speaker activity preempts TALK, both sides of the midpoint
        add(M, M,     1, 0, 0, 0, 7, S_TALK, 0, 1, 3'd1, 0, 0);
        add(M, 8'h81, 1, 0, 0, 0, 1, S_LIST, 1, 0, 3'd1, 0, 0);
        add(M, M,     1, 0, 0, 0, 1, S_TALK, 0, 1, 3'd1, 0, 0);
        add(M, 8'h7F, 1, 0, 0, 0, 1, S_LIST, 1, 0, 3'd1, 0, 0);
        add(M, M,     1, 0, 0, 0, 1, S_TALK, 0, 1, 3'd1, 0, 0);
        add(M, M,     0, 0, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        add(M, M, 0, 0, 1, 0, 7, S_LIST, 0, 0, 3'd1, 1, 0);
        add(M, M, 0, 0, 0, 0, 7, S_LIST, 0, 0, 3'd1, 1, 0);
        add(M, M, 0, 0, 1, 0, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        add(M, M, 0, 0, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        // noise gate: loud -> TALK, quiet -> HANG for 8 cycles
        add(M, M, 0, 1, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 1);
        add(M, M, 0, 0, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 1);
        add(8'hC0, M, 0, 0, 0, 0, 1, S_TALK, 0, 1, 3'd1, 0, 1);
        add(8'hC0, M, 0, 0, 0, 0, 2, S_TALK, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 1, S_HANG, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 7, S_HANG, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 1, S_LIST, 1, 0, 3'd1, 0, 1);
        add(8'hC0, M, 0, 0, 0, 0, 1, S_TALK, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 1, S_HANG, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 3, S_HANG, 0, 1, 3'd1, 0, 1);
        add(8'h3F, M, 0, 0, 0, 0, 1, S_TALK, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 1, S_HANG, 0, 1, 3'd1, 0, 1);
        add(8'h41, M, 0, 0, 0, 0, 7, S_HANG, 0, 1, 3'd1, 0, 1);
        add(8'h41, M, 0, 0, 0, 0, 1, S_LIST, 1, 0, 3'd1, 0, 1);
        add(8'h41, M, 0, 0, 0, 0, 2, S_LIST, 1, 0, 3'd1, 0, 1);
        add(8'h40, M, 0, 0, 0, 0, 1, S_TALK, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 1, S_HANG, 0, 1, 3'd1, 0, 1);
        add(M,     M, 0, 0, 0, 0, 8, S_LIST, 1, 0, 3'd1, 0, 1);
        add(M,     M, 0, 1, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        add(M,     M, 0, 0, 0, 0, 7, S_LIST, 1, 0, 3'd1, 0, 0);
        add(8'hC0, M, 0, 0, 0, 0, 2, S_LIST, 1, 0, 3'd1, 0, 0);
        // simultaneous mute and effect presses
        add(M, M, 0, 0, 1, 1, 7, S_LIST, 0, 0, 3'd2, 1, 0);
        add(M, M, 0, 0, 0, 0, 7, S_LIST, 0, 0, 3'd2, 1, 0);
        add(M, M, 1, 0, 0, 0, 7, S_TALK, 0, 1, 3'd2, 1, 0);

        foreach (tbl[i]) begin
            mic_aud = tbl[i].mic; spk_aud = tbl[i].spk;
            ptt_btn = tbl[i].ptt; ng_btn = tbl[i].ng;
            mute_btn = tbl[i].mute; effect_btn = tbl[i].eff;
            step(tbl[i].cyc);
            check_all(i, tbl[i].st, tbl[i].vol, tbl[i].effen, tbl[i].effect, tbl[i].mt, tbl[i].ngt);
        end

        // reset mid-TALK with ptt still held
        rst = 1'b1;
        step(1);
        check_all(901, S_LIST, 0, 0, 3'd0, 0, 0);
        rst = 1'b0;
        step(1);
        check_all(902, S_LIST, 1, 0, 3'd0, 0, 0);
        step(5);
        check_all(903, S_LIST, 1, 0, 3'd0, 0, 0);
        step(1);
        check_all(904, S_TALK, 0, 0, 3'd0, 0, 0);
        ptt_btn = 1'b0;
        step(6);
        check_all(905, S_TALK, 0, 0, 3'd0, 0, 0);
        step(1);
        check_all(906, S_LIST, 1, 0, 3'd0, 0, 0);

`ifdef TEAM_06_TALK_TIMEOUT_EN
        ptt_btn = 1'b1;
        step(7);
        check_all(910, S_TALK, 0, 0, 3'd0, 0, 0);
        step(15);
        check_all(911, S_TALK, 0, 0, 3'd0, 0, 0);
        step(1);
        check_all(912, S_LOCK, 1, 0, 3'd0, 0, 0);
        ptt_btn = 1'b0;
        step(6);
        check_all(913, S_LOCK, 1, 0, 3'd0, 0, 0);
        step(1);
        check_all(914, S_LIST, 1, 0, 3'd0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
